cache_controller: RTL
=====================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter INDEX, default 3, SHALL set cache index width (low address bits).
REQ-002 Parameter CACHESIZE, default 8, SHALL set the number of lines, which SHALL equal 2**INDEX.
REQ-003 Parameter MEMORYBITS, default 5, SHALL set the full memory address width; tag width = MEMORYBITS-INDEX.
REQ-004 Parameter DATAWIDTH, default 8, SHALL set the data word width.
REQ-005 Ports (name direction width meaning):
 clk  in  1  single clock, all state updates on posedge
 reset_n  in  1  asynchronous, active-low reset
 cpu_req  in  1  CPU request, held until cpu_done
 cpu_we  in  1  1=write, 0=read
 cpu_addr  in  MEMORYBITS  request address
 cpu_wdata  in  DATAWIDTH  write data
 cache_flush  in  1  invalidate all lines
 cpu_done  out  1  one-cycle completion pulse
 cpu_hit  out  1  valid with cpu_done; 1=hit
 cpu_rdata  out  DATAWIDTH  read data, valid with cpu_done
 tag_addr  out  INDEX  tag/data RAM index
 tag_in  out  MEMORYBITS-INDEX  tag to store
 tag_re  out  1  tag RAM read enable
 tag_we  out  1  tag RAM write enable
 tag_out  in  MEMORYBITS-INDEX  tag RAM data, registered, 1-cycle latency
 data_we  out  1  data RAM write enable
 data_wdata  out  DATAWIDTH  data RAM write data
 data_rdata  in  DATAWIDTH  data RAM read data, 1-cycle latency
 mem_req, mem_we  out  1  main-memory request / write
 mem_addr  out  MEMORYBITS;  mem_wdata  out  DATAWIDTH
 mem_ack  in  1;  mem_rdata  in  DATAWIDTH

Function
REQ-006 FSM states SHALL be IDLE, LOOKUP, COMPARE, REFILL, FILL, WRITE_MEM, RESPOND.
REQ-007 IDLE: cache_flush SHALL clear all valid bits in one cycle and take priority over cpu_req; else cpu_req SHALL latch addr/we/wdata and go to LOOKUP.
REQ-008 LOOKUP: tag_addr=latched index, tag_re=1; next COMPARE.
REQ-009 COMPARE: hit = valid[index] AND tag_out==latched tag; read hit -> RESPOND with cpu_rdata=data_rdata, cpu_hit=1; read miss -> REFILL; any write -> WRITE_MEM.
REQ-010 Write hit SHALL assert data_we with cpu_wdata in COMPARE (write-through); write miss SHALL NOT allocate.
REQ-011 REFILL: mem_req=1, mem_we=0, mem_addr=latched address until mem_ack; capture mem_rdata on ack; next FILL.
REQ-012 FILL: tag_we=1, tag_in=latched tag, data_we=1 with captured data, set valid[index]; next RESPOND with cpu_hit=0.
REQ-013 WRITE_MEM: mem_req=1, mem_we=1, mem_wdata=latched data until mem_ack; next RESPOND; cpu_hit reflects the COMPARE result.
REQ-014 RESPOND: cpu_done=1 for exactly one cycle; next IDLE.
REQ-015 Read-hit latency SHALL be 3 cycles from the accepting edge to cpu_done.
REQ-016 mem_ack asserted in the first mem_req cycle SHALL be accepted; mem_ack outside REFILL/WRITE_MEM SHALL be ignored.
REQ-017 cpu_req and cache_flush outside IDLE SHALL be ignored.
REQ-018 All RAM/memory enables SHALL be 0 in every state not naming them.

Reset
REQ-019 reset_n low SHALL force IDLE, clear all valid bits, and drive all outputs to 0, including mid-REFILL/WRITE_MEM (transaction abandoned, no cpu_done).

Configuration
REQ-020 With CACHE_STATS_EN defined, outputs hit_count and miss_count (16 bits each) SHALL count read hits/misses at COMPARE, saturate at 16'hFFFF, and reset to 0; without it, the ports and logic SHALL be absent.

Structure
REQ-021 Package cache_pkg SHALL hold the state enum and default parameter constants.
REQ-022 The valid-bit array with flush SHALL be sub-module cache_valid_bits.

Verification
REQ-023 Reset, read 5'b10011 with mem_rdata=8'hA5 -> REFILL, tag_we with tag 2'b10 at index 3, cpu_done, cpu_hit=0, rdata=A5.
REQ-024 Repeat read 5'b10011 -> cpu_done 3 cycles after accept, cpu_hit=1, rdata=A5, no mem_req.
REQ-025 Write 5'b10011 data 8'h3C -> data_we in COMPARE, mem_we to 5'b10011, cpu_hit=1; next read returns 3C as a hit.
REQ-026 cache_flush then read 5'b10011 -> miss with REFILL.
REQ-027 reset_n low during REFILL -> IDLE, no cpu_done, following read of the same address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller:
// FSM state encoding and default geometry.
package cache_pkg;

    localparam int DEF_INDEX      = 3;
    localparam int DEF_CACHESIZE  = 8;
    localparam int DEF_MEMORYBITS = 5;
    localparam int DEF_DATAWIDTH  = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        REFILL,
        FILL,
        WRITE_MEM,
        RESPOND
    } state_t;

endpackage

// File: rtl/cache_valid_bits.sv
// Per-line valid flags with single-cycle flush; set on line fill, read
// combinationally by index.
module cache_valid_bits #(
    parameter int INDEX     = 3,
    parameter int CACHESIZE = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             set_en,
    input  logic [INDEX-1:0] set_idx,
    input  logic [INDEX-1:0] rd_idx,
    output logic             valid
);

    logic [CACHESIZE-1:0] valid_q;

    // NOTE: unlike data/tag storage, this array must be reset, since a stale valid bit would turn garbage RAM contents into a hit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (set_en) begin
            valid_q[set_idx] <= 1'b1;
        end
    end

    assign valid = valid_q[rd_idx];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller driving
// external tag/data RAMs. Define CACHE_STATS_EN to add read hit/miss counters.
module cache_controller
    import cache_pkg::*;
#(
    parameter int INDEX      = DEF_INDEX,
    parameter int CACHESIZE  = DEF_CACHESIZE,
    parameter int MEMORYBITS = DEF_MEMORYBITS,
    parameter int DATAWIDTH  = DEF_DATAWIDTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cpu_req,
    input  logic                        cpu_we,
    input  logic [MEMORYBITS-1:0]       cpu_addr,
    input  logic [DATAWIDTH-1:0]        cpu_wdata,
    input  logic                        cache_flush,
    output logic                        cpu_done,
    output logic                        cpu_hit,
    output logic [DATAWIDTH-1:0]        cpu_rdata,
    output logic [INDEX-1:0]            tag_addr,
    output logic [MEMORYBITS-INDEX-1:0] tag_in,
    output logic                        tag_re,
    output logic                        tag_we,
    input  logic [MEMORYBITS-INDEX-1:0] tag_out,
    output logic                        data_we,
    output logic [DATAWIDTH-1:0]        data_wdata,
    input  logic [DATAWIDTH-1:0]        data_rdata,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [MEMORYBITS-1:0]       mem_addr,
    output logic [DATAWIDTH-1:0]        mem_wdata,
    input  logic                        mem_ack,
    input  logic [DATAWIDTH-1:0]        mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]                 hit_count,
    output logic [15:0]                 miss_count
`endif
);

    state_t                      state, next_state;
    logic [MEMORYBITS-1:0]       addr_q;
    logic                        we_q;
    logic [DATAWIDTH-1:0]        wdata_q;
    logic                        hit_q;
    logic [DATAWIDTH-1:0]        rdata_q;
    logic                        line_valid;
    logic                        lookup_hit;
    logic                        accept;
    logic                        flush;

    wire [INDEX-1:0]            idx = addr_q[INDEX-1:0];
    wire [MEMORYBITS-INDEX-1:0] tag = addr_q[MEMORYBITS-1:INDEX];

    assign flush      = (state == IDLE) && cache_flush;
    assign accept     = (state == IDLE) && !cache_flush && cpu_req;
    assign lookup_hit = line_valid && (tag_out == tag);

    cache_valid_bits #(
        .INDEX     (INDEX),
        .CACHESIZE (CACHESIZE)
    ) u_valid_bits (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .set_en  (state == FILL),
        .set_idx (idx),
        .rd_idx  (idx),
        .valid   (line_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            hit_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                addr_q  <= cpu_addr;
                we_q    <= cpu_we;
                wdata_q <= cpu_wdata;
            end
            // rdata_q doubles as the refill buffer written into the data RAM in FILL.
            if (state == COMPARE) begin
                hit_q   <= lookup_hit;
                rdata_q <= data_rdata;
            end
            if (state == REFILL && mem_ack) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // NOTE: every output and next_state gets a default first so no path through the case can infer a latch.
    always_comb begin
        next_state = state;
        cpu_done   = 1'b0;
        cpu_hit    = 1'b0;
        cpu_rdata  = '0;
        tag_addr   = '0;
        tag_in     = '0;
        tag_re     = 1'b0;
        tag_we     = 1'b0;
        data_we    = 1'b0;
        data_wdata = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (accept) next_state = LOOKUP;
            end
            LOOKUP: begin
                tag_addr   = idx;
                tag_re     = 1'b1;
                next_state = COMPARE;
            end
            COMPARE: begin
                tag_addr = idx;
                if (we_q) begin
                    if (lookup_hit) begin
                        data_we    = 1'b1;
                        data_wdata = wdata_q;
                    end
                    next_state = WRITE_MEM;
                end else begin
                    next_state = lookup_hit ? RESPOND : REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) next_state = FILL;
            end
            FILL: begin
                tag_addr   = idx;
                tag_we     = 1'b1;
                tag_in     = tag;
                data_we    = 1'b1;
                data_wdata = rdata_q;
                next_state = RESPOND;
            end
            WRITE_MEM: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (mem_ack) next_state = RESPOND;
            end
            RESPOND: begin
                cpu_done   = 1'b1;
                cpu_hit    = hit_q;
                cpu_rdata  = rdata_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef CACHE_STATS_EN
    wire read_lookup = (state == COMPARE) && !we_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (read_lookup) begin
            if (lookup_hit && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (!lookup_hit && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule
